an_ordset_gen: RTL and testbench
================================

Name: an_ordset_gen

Overview:
- Synthesisable, parametrised successor to the behavioural auto-negotiation ordered-set sender.
- Generates the 1000BASE-X/SGMII auto-negotiation /C/ ordered-set stream as pre-encoder 8b/10b symbols: one byte plus K flag per clock.
- Adds a configurable acknowledge phase, abort, a start/done handshake and a repeat-count port.
- Sits between the AN control logic and the 8b/10b encoder / SGMII serialiser in entry_point.

Parameters:
- COUNT_W, 8, width of an_count and sets_sent.
- ACK_PHASE, 1, 1 = after the config phase, send an_count further sets with bit 14 (ACK) forced to 1; 0 = skip the ACK phase.
- IDLE_SEL, 0, idle ordered set: 0 = /I2/ (BC,50); 1 = /I1/ (BC,C5).

Ports:
- sgmii_clk_in  in  1  symbol clock, 125 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- start  in  1  request to begin a negotiation sequence.
- abort  in  1  request to stop the sequence early.
- an_config  in  16  config register value; captured when start is accepted.
- an_count  in  COUNT_W  ordered sets per phase; captured when start is accepted.
- tx_data  out  8  symbol byte.
- tx_k  out  1  1 = K character.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- phase  out  2  0 = IDLE, 1 = CFG, 2 = ACK.
- sets_sent  out  COUNT_W  ordered sets completed in the current phase.

Behaviour:
- Reset values (immediate, asynchronous):
  - state IDLE, sym_idx = 0.
  - tx_data = 8'hBC, tx_k = 1.
  - busy = 0, done = 0, aborted = 0, phase = 0, sets_sent = 0.
  - start_pending = 0, abort_pending = 0.
- IDLE:
  - Emits the idle set continuously: BC(k=1), then 50 or C5 per IDLE_SEL (k=0); sym_idx toggles 0/1.
  - start high in any IDLE cycle sets start_pending, latches an_config and an_count, and raises busy on the next edge.
  - An an_count of 0 is latched as 1.
  - Start while busy is ignored.
- IDLE -> CFG transition:
  - Occurs only after the idle set's 2nd symbol; idle sets are never truncated.
  - First CFG symbol appears 1–2 cycles after start, depending on sym_idx.
- CFG and ACK ordered sets:
  - 4 symbols each: BC(k), D, cfg[7:0], cfg[15:8]. Low byte goes first.
  - D alternates B5 (/C1/) and 42 (/C2/), starting with /C1/ at phase entry.
  - In ACK, the transmitted config is latched config | 16'h4000.
  - sets_sent increments on each set's 4th symbol and saturates at 2^COUNT_W−1.
- Phase completion:
  - When sets_sent reaches the latched count at a set boundary: CFG -> ACK (ACK_PHASE = 1) or CFG -> IDLE (ACK_PHASE = 0); ACK -> IDLE.
  - sets_sent clears on phase change.
  - done pulses for 1 cycle together with the first idle symbol; busy falls on the same edge.
- abort:
  - Valid when busy; sets abort_pending. Ignored in IDLE when not busy.
  - The current ordered set completes, then the block enters IDLE.
  - aborted pulses with the first idle symbol; done is not asserted.
  - If the normal end and abort_pending fall on the same boundary, done wins and aborted is suppressed.
- start and abort in the same cycle while IDLE: start is accepted, abort is ignored.
- Mid-operation reset: outputs return to reset values immediately; no partial set resumes after release.
- Outputs are registered; no combinational path from inputs to tx_data or tx_k.
- Latched config and count are stable for the whole sequence; changes on the an_config input have no effect until the next start.

Test Plan:
- Reset release, no start -> stream BC,50 repeating; busy = 0; phase = 0; no done.
- start with an_config = 16'h01A0, an_count = 2, ACK_PHASE = 1:
  - Expect BC,B5,A0,01, BC,42,A0,01, then BC,B5,A0,41, BC,42,A0,41, then BC,50.
  - done pulses once with that BC; busy spans all 16 config symbols.
- an_count = 0, ACK_PHASE = 0 -> exactly one /C1/ set (BC,B5,cfg_lo,cfg_hi), then idle and done.
- abort asserted on the 2nd symbol of the 3rd CFG set (an_count = 5):
  - That set completes (4 symbols), then BC,50.
  - aborted = 1 for one cycle; done never asserts; phase = 0.
- start asserted during idle sym_idx 0 vs sym_idx 1 -> first BC of /C1/ at +2 and +1 cycles respectively; no idle set truncated.
- reset asserted mid-ACK phase:
  - tx_data = BC, tx_k = 1, busy = 0 in the same cycle (asynchronous).
  - After release, idle stream; a new start begins again with /C1/ and sets_sent = 0.

Source files
------------

// File: rtl/an_ordset_gen.sv
// Auto-negotiation /C/ ordered-set generator: emits pre-encoder 8b/10b symbols
// (byte + K flag) for the idle, config and acknowledge phases of 1000BASE-X/SGMII AN.
module an_ordset_gen #(
    parameter int COUNT_W   = 8,
    parameter bit ACK_PHASE = 1'b1,
    parameter bit IDLE_SEL  = 1'b0
) (
    input  logic               sgmii_clk_in,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        an_config,
    input  logic [COUNT_W-1:0] an_count,
    output logic [7:0]         tx_data,
    output logic               tx_k,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [1:0]         phase,
    output logic [COUNT_W-1:0] sets_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic [7:0] D_C1   = 8'hB5;
    localparam logic [7:0] D_C2   = 8'h42;
    localparam logic [7:0] IDLE_D = IDLE_SEL ? 8'hC5 : 8'h50;
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [1:0]         sym_idx_q, sym_idx_d;
    logic               c2_q, c2_d;
    logic [15:0]        cfg_q, cfg_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] sets_q, sets_d;
    logic               start_pend_q, start_pend_d;
    logic               abort_pend_q, abort_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_k_q, tx_k_d;
    logic [15:0]        cfg_tx;
    logic               start_acc;

    assign start_acc = (state_q == ST_IDLE) && !busy_q && start;
    assign cfg_tx    = (state_q == ST_ACK) ? (cfg_q | 16'h4000) : cfg_q;

    always_comb begin
        state_d      = state_q;
        sym_idx_d    = sym_idx_q;
        c2_d         = c2_q;
        cfg_d        = cfg_q;
        cnt_d        = cnt_q;
        sets_d       = sets_q;
        start_pend_d = start_pend_q;
        abort_pend_d = abort_pend_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        tx_data_d    = tx_data_q;
        tx_k_d       = tx_k_q;

        if (busy_q && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    start_pend_d = 1'b1;
                    busy_d       = 1'b1;
                    cfg_d        = an_config;
                    cnt_d        = (an_count == '0) ? COUNT_W'(1) : an_count;
                end
                // Leave IDLE only once the idle set's second symbol has gone out.
                if (sym_idx_q == 2'd1 && (start_pend_q || start_acc)) begin
                    state_d      = ST_CFG;
                    start_pend_d = 1'b0;
                    sym_idx_d    = 2'd0;
                    c2_d         = 1'b0;
                    sets_d       = '0;
                    tx_data_d    = K28_5;
                    tx_k_d       = 1'b1;
                end else if (sym_idx_q == 2'd0) begin
                    sym_idx_d = 2'd1;
                    tx_data_d = IDLE_D;
                    tx_k_d    = 1'b0;
                end else begin
                    sym_idx_d = 2'd0;
                    tx_data_d = K28_5;
                    tx_k_d    = 1'b1;
                end
            end
            default: begin
                case (sym_idx_q)
                    2'd0: begin
                        sym_idx_d = 2'd1;
                        tx_data_d = c2_q ? D_C2 : D_C1;
                        tx_k_d    = 1'b0;
                    end
                    2'd1: begin
                        sym_idx_d = 2'd2;
                        tx_data_d = cfg_tx[7:0];
                        tx_k_d    = 1'b0;
                    end
                    2'd2: begin
                        sym_idx_d = 2'd3;
                        tx_data_d = cfg_tx[15:8];
                        tx_k_d    = 1'b0;
                        if (sets_q != CNT_MAX) begin
                            sets_d = sets_q + COUNT_W'(1);
                        end
                    end
                    default: begin
                        // Set boundary: normal completion takes priority over abort.
                        sym_idx_d = 2'd0;
                        tx_data_d = K28_5;
                        tx_k_d    = 1'b1;
                        if (sets_q == cnt_q) begin
                            sets_d = '0;
                            c2_d   = 1'b0;
                            if (state_q == ST_CFG && ACK_PHASE) begin
                                state_d = ST_ACK;
                            end else begin
                                state_d      = ST_IDLE;
                                busy_d       = 1'b0;
                                done_d       = 1'b1;
                                abort_pend_d = 1'b0;
                            end
                        end else if (abort_pend_q || abort) begin
                            state_d      = ST_IDLE;
                            sets_d       = '0;
                            c2_d         = 1'b0;
                            busy_d       = 1'b0;
                            aborted_d    = 1'b1;
                            abort_pend_d = 1'b0;
                        end else begin
                            c2_d = ~c2_q;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge sgmii_clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sym_idx_q    <= 2'd0;
            c2_q         <= 1'b0;
            cfg_q        <= 16'h0000;
            cnt_q        <= COUNT_W'(1);
            sets_q       <= '0;
            start_pend_q <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            tx_data_q    <= K28_5;
            tx_k_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            sym_idx_q    <= sym_idx_d;
            c2_q         <= c2_d;
            cfg_q        <= cfg_d;
            cnt_q        <= cnt_d;
            sets_q       <= sets_d;
            start_pend_q <= start_pend_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            tx_data_q    <= tx_data_d;
            tx_k_q       <= tx_k_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_k      = tx_k_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign phase     = state_q;
    assign sets_sent = sets_q;

endmodule

// File: tb/tb_an_ordset_gen.sv
// Bench for an_ordset_gen: two instances (ACK phase with /I2/, no ACK phase with /I1/)
// checked cycle by cycle against per-instance expected-symbol queues.
module tb_an_ordset_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b, abort;
    logic [15:0] an_config;
    logic [7:0]  an_count;

    logic [7:0]  data_a, data_b, sets_a, sets_b;
    logic        k_a, k_b, busy_a, busy_b, done_a, done_b, ab_a, ab_b;
    logic [1:0]  ph_a, ph_b;

    // Expected word: {phase, aborted, done, busy, tx_k, tx_data, sets_sent}
    logic [21:0] exp_a[$];
    logic [21:0] exp_b[$];
    int          par[2];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #4 clk = ~clk;

    an_ordset_gen #(.COUNT_W(8), .ACK_PHASE(1'b1), .IDLE_SEL(1'b0)) dut_a (
        .sgmii_clk_in(clk), .reset(reset), .start(start_a), .abort(abort),
        .an_config(an_config), .an_count(an_count), .tx_data(data_a), .tx_k(k_a),
        .busy(busy_a), .done(done_a), .aborted(ab_a), .phase(ph_a), .sets_sent(sets_a)
    );

    an_ordset_gen #(.COUNT_W(8), .ACK_PHASE(1'b0), .IDLE_SEL(1'b1)) dut_b (
        .sgmii_clk_in(clk), .reset(reset), .start(start_b), .abort(abort),
        .an_config(an_config), .an_count(an_count), .tx_data(data_b), .tx_k(k_b),
        .busy(busy_b), .done(done_b), .aborted(ab_b), .phase(ph_b), .sets_sent(sets_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] mk(input logic [1:0] ph, input logic ab, input logic dn,
                                       input logic bs, input logic k, input logic [7:0] d,
                                       input logic [7:0] ss);
        return {ph, ab, dn, bs, k, d, ss};
    endfunction

    function automatic logic [7:0] idle2(input int d);
        return (d == 0) ? 8'h50 : 8'hC5;
    endfunction

    task automatic push(input int d, input logic [21:0] w);
        if (d == 0) exp_a.push_back(w);
        else        exp_b.push_back(w);
    endtask

    task automatic push_idle(input int d, input int n, input logic bs);
        for (int i = 0; i < n; i++) begin
            if (par[d] == 0) push(d, mk(2'd0, 1'b0, 1'b0, bs, 1'b1, 8'hBC, 8'd0));
            else             push(d, mk(2'd0, 1'b0, 1'b0, bs, 1'b0, idle2(d), 8'd0));
            par[d] ^= 1;
        end
    endtask

    task automatic push_sets(input int d, input logic [1:0] ph, input logic [15:0] cfg, input int n);
        logic [7:0] s8;
        for (int s = 0; s < n; s++) begin
            s8 = 8'(s);
            push(d, mk(ph, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBC, s8));
            push(d, mk(ph, 1'b0, 1'b0, 1'b1, 1'b0, (s % 2 == 1) ? 8'h42 : 8'hB5, s8));
            push(d, mk(ph, 1'b0, 1'b0, 1'b1, 1'b0, cfg[7:0], s8));
            push(d, mk(ph, 1'b0, 1'b0, 1'b1, 1'b0, cfg[15:8], s8 + 8'd1));
        end
    endtask

    task automatic pad();
        while (exp_a.size() < exp_b.size()) push_idle(0, 1, 1'b0);
        while (exp_b.size() < exp_a.size()) push_idle(1, 1, 1'b0);
    endtask

    task automatic step();
        logic [21:0] w;
        @(posedge clk);
        #2;
        if (exp_a.size() == 0) check_eq("exp_a_avail", 64'(exp_a.size() != 0), 64'd1);
        else begin
            w = exp_a.pop_front();
            check_eq("dut_a_sym", {42'd0, ph_a, ab_a, done_a, busy_a, k_a, data_a, sets_a}, {42'd0, w});
        end
        if (exp_b.size() == 0) check_eq("exp_b_avail", 64'(exp_b.size() != 0), 64'd1);
        else begin
            w = exp_b.pop_front();
            check_eq("dut_b_sym", {42'd0, ph_b, ab_b, done_b, busy_b, k_b, data_b, sets_b}, {42'd0, w});
        end
    endtask

    task automatic run_idle(input int n);
        push_idle(0, n, 1'b0);
        push_idle(1, n, 1'b0);
        repeat (n) step();
    endtask

    task automatic align(input int want);
        if (par[0] != want) run_idle(1);
    endtask

    // abort_set > 0: abort pulsed during the D symbol of that (1-based) CFG set.
    task automatic run_txn(input int d, input logic [15:0] cfg, input logic [7:0] cnt,
                           input bit ack, input int abort_set, input bit abort_with_start,
                           input int max_steps);
        int lead;
        int n;
        int total;
        lead = par[d];
        if (par[d] == 1) push_idle(d, 1, 1'b1);
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        if (abort_set > 0) begin
            push_sets(d, 2'd1, cfg, abort_set);
            push(d, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBC, 8'd0));
        end else begin
            push_sets(d, 2'd1, cfg, n);
            if (ack) push_sets(d, 2'd2, cfg | 16'h4000, n);
            push(d, mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hBC, 8'd0));
        end
        par[d] = 1;
        pad();
        total = exp_a.size();
        if (max_steps > 0 && max_steps < total) total = max_steps;

        an_config = cfg;
        an_count  = cnt;
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        abort = abort_with_start;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        abort   = 1'b0;
        an_config = 16'($urandom_range(0, 65535));
        an_count  = 8'($urandom_range(0, 255));
        for (int t = 2; t <= total; t++) begin
            if (t == 4) begin
                if (d == 0) start_a = 1'b1;
                else        start_b = 1'b1;
            end
            if (abort_set > 0 && t == lead + 4 * (abort_set - 1) + 3) abort = 1'b1;
            step();
            start_a = 1'b0;
            start_b = 1'b0;
            abort   = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        abort     = 1'b0;
        an_config = 16'h0000;
        an_count  = 8'd0;
        #1;
        check_eq("rst_tx_data", 64'(data_a), 64'hBC);
        check_eq("rst_tx_k", 64'(k_a), 64'd1);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_done_aborted", 64'({done_a, ab_a}), 64'd0);
        check_eq("rst_phase_sets", 64'({ph_a, sets_a}), 64'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        par[0] = 1;
        par[1] = 1;

        run_idle(6);
        align(1);
        run_txn(0, 16'h01A0, 8'd2, 1'b1, 0, 1'b0, 0);
        run_idle(3);
        align(0);
        run_txn(0, 16'($urandom_range(0, 65535)), 8'd1, 1'b1, 0, 1'b0, 0);
        run_idle(2);
        run_txn(1, 16'h9C3E, 8'd0, 1'b0, 0, 1'b1, 0);
        run_idle(4);
        run_txn(0, 16'h5A21, 8'd5, 1'b1, 3, 1'b0, 0);
        run_idle(3);
        run_txn(0, 16'h1234, 8'd3, 1'b1, 0, 1'b0, 16);

        // Asynchronous reset in the middle of the ACK phase.
        #3 reset = 1'b1;
        #1;
        check_eq("midrst_tx_data", 64'(data_a), 64'hBC);
        check_eq("midrst_tx_k", 64'(k_a), 64'd1);
        check_eq("midrst_busy", 64'(busy_a), 64'd0);
        check_eq("midrst_phase_sets", 64'({ph_a, sets_a}), 64'd0);
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        par[0] = 1;
        par[1] = 1;

        run_idle(5);
        run_txn(0, 16'hBEEF, 8'd1, 1'b1, 0, 1'b0, 0);
        run_idle(4);

        check_eq("exp_a_drained", 64'(exp_a.size()), 64'd0);
        check_eq("exp_b_drained", 64'(exp_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
